// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the operand-fetch slice of the pipeline:
//   DATA_W / REG_W  - datapath and register-index widths
//   CNT_W           - width of the stall-cycle counter
//   wd_sel_e        - write-back data select encodings (alu / dram / pc+4)
//   slot_t          - per-stage descriptor {valid, rd, we, is_load} carried
//                     down the EX -> MEM -> WB shadow pipeline
//   slot_match()    - true when a slot will write the register rs (never x0)
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        WD_ALU  = 2'b00,
        WD_DRAM = 2'b01,
        WD_PC4  = 2'b11
    } wd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // x0 is hard-wired to zero, so a write to it never produces a value
    // that a reader could depend on.
    function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] rs);
        return s.valid && s.we && (s.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// ----------------------------------------------------------------------------
// operand_fetch_if
// Bundles every ID-stage / pipeline / register-file signal that the operand
// fetch block consumes or produces.
//   master modport : driver side (decoder, pipeline, register file)
//   slave modport  : operand_fetch itself
// Signals:
//   id_valid, rs1, rs2, id_rd, id_we, id_is_load, flush   - ID instruction
//   ex_result, mem_result, wb_data                        - in-flight values
//   rf_rR1, rf_rR2 (to RF), rf_rD1, rf_rD2 (from RF)       - RF read ports
//   op1, op2, stall, stall_cnt                            - results
// ----------------------------------------------------------------------------
interface operand_fetch_if;
    import cpu_pkg::*;

    logic              id_valid;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  rf_rR1;
    logic [REG_W-1:0]  rf_rR2;
    logic [DATA_W-1:0] rf_rD1;
    logic [DATA_W-1:0] rf_rD2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, rs1, rs2, id_rd, id_we, id_is_load, flush,
        output ex_result, mem_result, wb_data, rf_rD1, rf_rD2,
        input  rf_rR1, rf_rR2, op1, op2, stall, stall_cnt
    );

    modport slave (
        input  id_valid, rs1, rs2, id_rd, id_we, id_is_load, flush,
        input  ex_result, mem_result, wb_data, rf_rD1, rf_rD2,
        output rf_rR1, rf_rR2, op1, op2, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Resolves one source operand against the EX/MEM/WB shadow slots.
// Build option: OPERAND_FETCH_FWD_EN
//   defined   - youngest matching slot wins: EX, then MEM, then WB, then RF
//   undefined - operand always comes from the register file; hazards are
//               handled by interlocking in the parent
// In both builds rs==0 yields zero.
// Ports:
//   i_rs                               - source register index
//   i_ex_slot, i_mem_slot, i_wb_slot   - shadow pipeline descriptors
//   i_ex_result, i_mem_result, i_wb_data, i_rf_data - candidate values
//   o_op                               - resolved operand
//   o_hit_ex                           - EX slot will write i_rs
//   o_hit_any                          - any slot will write i_rs
// ----------------------------------------------------------------------------
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0]  i_rs,
    input  slot_t             i_ex_slot,
    input  slot_t             i_mem_slot,
    input  slot_t             i_wb_slot,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_op,
    output logic              o_hit_ex,
    output logic              o_hit_any
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_ex  = slot_match(i_ex_slot,  i_rs);
    assign w_hit_mem = slot_match(i_mem_slot, i_rs);
    assign w_hit_wb  = slot_match(i_wb_slot,  i_rs);

    assign o_hit_ex  = w_hit_ex;
    assign o_hit_any = w_hit_ex | w_hit_mem | w_hit_wb;

    // The load flag only matters to the parent's hazard check.
    logic w_unused_slot;
    assign w_unused_slot = ^{i_ex_slot.is_load, i_mem_slot.is_load, i_wb_slot.is_load};

`ifdef OPERAND_FETCH_FWD_EN
    always_comb begin
        o_op = i_rf_data;
        if (i_rs == '0) begin
            o_op = '0;
        end else if (w_hit_ex) begin
            o_op = i_ex_result;
        end else if (w_hit_mem) begin
            o_op = i_mem_result;
        end else if (w_hit_wb) begin
            o_op = i_wb_data;
        end
    end
`else
    always_comb begin
        o_op = i_rf_data;
        if (i_rs == '0) begin
            o_op = '0;
        end
    end

    logic w_unused_data;
    assign w_unused_data = ^{i_ex_result, i_mem_result, i_wb_data};
`endif

endmodule

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
// ID-stage operand resolution with hazard detection. Keeps a shadow copy
// of the destinations of the instructions in EX, MEM and WB, resolves both
// source operands combinationally, and stalls ID when a value cannot be
// supplied in time.
// Build option: OPERAND_FETCH_FWD_EN
//   defined   - full forwarding; only a load in EX feeding ID stalls (1 cycle)
//   undefined - no forwarding; ID stalls while any EX/MEM/WB slot still
//               has to write one of its sources
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears slots and stall counter)
//   bus    - operand_fetch_if.slave (ID inputs, pipeline values, RF ports,
//            op1/op2, stall, stall_cnt)
// ----------------------------------------------------------------------------
module operand_fetch
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    slot_t            w_ex_next;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [REG_W-1:0]  w_rs      [2];
    logic [DATA_W-1:0] w_rf_data [2];
    logic [DATA_W-1:0] w_op      [2];
    logic              w_hit_ex  [2];
    logic              w_hit_any [2];
    logic              w_hazard;
    logic              w_stall;

    // ---------------- register-file read addresses ----------------
    assign bus.rf_rR1 = bus.rs1;
    assign bus.rf_rR2 = bus.rs2;

    assign w_rs[0]      = bus.rs1;
    assign w_rs[1]      = bus.rs2;
    assign w_rf_data[0] = bus.rf_rD1;
    assign w_rf_data[1] = bus.rf_rD2;

    // ---------------- one resolver per source operand ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            fwd_mux u_fwd_mux (
                .i_rs         (w_rs[gi]),
                .i_ex_slot    (r_ex),
                .i_mem_slot   (r_mem),
                .i_wb_slot    (r_wb),
                .i_ex_result  (bus.ex_result),
                .i_mem_result (bus.mem_result),
                .i_wb_data    (bus.wb_data),
                .i_rf_data    (w_rf_data[gi]),
                .o_op         (w_op[gi]),
                .o_hit_ex     (w_hit_ex[gi]),
                .o_hit_any    (w_hit_any[gi])
            );
        end
    endgenerate

    assign bus.op1 = w_op[0];
    assign bus.op2 = w_op[1];

    // ---------------- hazard detection ----------------
`ifdef OPERAND_FETCH_FWD_EN
    // A load's data only exists after MEM, so an EX-stage load cannot be
    // forwarded. One bubble moves it into MEM where it can.
    assign w_hazard = r_ex.is_load & (w_hit_ex[0] | w_hit_ex[1]);

    logic w_unused_hit;
    assign w_unused_hit = w_hit_any[0] ^ w_hit_any[1];
`else
    // Without forwarding the reader waits until the producer has left WB
    // and the register file holds the new value.
    assign w_hazard = w_hit_any[0] | w_hit_any[1];

    logic w_unused_hit;
    assign w_unused_hit = w_hit_ex[0] ^ w_hit_ex[1];
`endif

    // A flushed ID instruction is dead, so it never needs to wait.
    assign w_stall   = bus.id_valid & ~bus.flush & w_hazard;
    assign bus.stall = w_stall;

    // ---------------- next EX slot ----------------
    always_comb begin
        w_ex_next = SLOT_BUBBLE;
        if (bus.id_valid && !w_stall && !bus.flush) begin
            w_ex_next.valid   = 1'b1;
            w_ex_next.rd      = bus.id_rd;
            w_ex_next.we      = bus.id_we;
            w_ex_next.is_load = bus.id_is_load;
        end
    end

    // ---------------- shadow pipeline and stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= SLOT_BUBBLE;
            r_mem       <= SLOT_BUBBLE;
            r_wb        <= SLOT_BUBBLE;
            r_stall_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_next;
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch
// Self-checking bench for operand_fetch. Directed table, hand-written
// multi-cycle sequences (load-use, flush, interlock length, mid-stream
// reset) and a randomized phase checked against an age-indexed model of
// the in-flight instructions. Honours OPERAND_FETCH_FWD_EN.
// ----------------------------------------------------------------------------
module tb_operand_fetch;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    operand_fetch_if ofi ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ofi)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // hist[a] is the instruction that entered EX (a+1) edges ago.
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ins_t;

    ins_t hist [3];
    int   m_cnt;

    function automatic bit hits(input ins_t p, input int rs);
        return p.v && p.we && (p.rd == rs) && (rs != 0);
    endfunction

    function automatic logic [31:0] m_op(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'h0;
`ifdef OPERAND_FETCH_FWD_EN
        begin
            logic [31:0] vals [3];
            vals[0] = ofi.ex_result;
            vals[1] = ofi.mem_result;
            vals[2] = ofi.wb_data;
            for (int a = 0; a < 3; a++) begin
                if (hits(hist[a], int'(rs))) return vals[a];
            end
        end
`endif
        return rf;
    endfunction

    function automatic bit m_stall();
        if (!ofi.id_valid || ofi.flush) return 1'b0;
`ifdef OPERAND_FETCH_FWD_EN
        return hist[0].ld && (hits(hist[0], int'(ofi.rs1)) || hits(hist[0], int'(ofi.rs2)));
`else
        for (int a = 0; a < 3; a++) begin
            if (hits(hist[a], int'(ofi.rs1)) || hits(hist[a], int'(ofi.rs2))) return 1'b1;
        end
        return 1'b0;
`endif
    endfunction

    task automatic m_clock(input bit st);
        ins_t n;
        n.v  = ofi.id_valid && !st && !ofi.flush;
        n.rd = int'(ofi.id_rd);
        n.we = ofi.id_we;
        n.ld = ofi.id_is_load;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = n;
        if (st && m_cnt < 65535) m_cnt++;
    endtask

    task automatic m_reset();
        for (int a = 0; a < 3; a++) hist[a] = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        m_cnt = 0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int r1, input int r2, input int rd,
                         input bit we, input bit ld, input bit fl,
                         input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
                         input logic [31:0] d1, input logic [31:0] d2);
        ofi.id_valid   = v;
        ofi.rs1        = 5'(r1);
        ofi.rs2        = 5'(r2);
        ofi.id_rd      = 5'(rd);
        ofi.id_we      = we;
        ofi.id_is_load = ld;
        ofi.flush      = fl;
        ofi.ex_result  = ex;
        ofi.mem_result = mem;
        ofi.wb_data    = wb;
        ofi.rf_rD1     = d1;
        ofi.rf_rD2     = d2;
    endtask

    // One cycle: check outputs mid-cycle against the model, then clock it.
    task automatic step(input string tag, output bit dut_st, output logic [31:0] dut_op1);
        bit          st;
        logic [31:0] e1;
        logic [31:0] e2;
        @(negedge clk);
        st = m_stall();
        e1 = m_op(ofi.rs1, ofi.rf_rD1);
        e2 = m_op(ofi.rs2, ofi.rf_rD2);
        dut_st  = ofi.stall;
        dut_op1 = ofi.op1;
        $display("[%s] v=%0d rs1=%0d rs2=%0d rd=%0d fl=%0d -> op1=%h op2=%h stall=%0d cnt=%0d",
                 tag, ofi.id_valid, ofi.rs1, ofi.rs2, ofi.id_rd, ofi.flush,
                 ofi.op1, ofi.op2, ofi.stall, ofi.stall_cnt);
        check({tag, "/op1"},   ofi.op1, e1);
        check({tag, "/op2"},   ofi.op2, e2);
        check({tag, "/stall"}, {31'b0, ofi.stall}, {31'b0, st});
        check({tag, "/cnt"},   {16'b0, ofi.stall_cnt}, 32'(m_cnt));
        check({tag, "/rR1"},   {27'b0, ofi.rf_rR1}, {27'b0, ofi.rs1});
        check({tag, "/rR2"},   {27'b0, ofi.rf_rR2}, {27'b0, ofi.rs2});
        @(posedge clk);
        m_clock(st);
        #1;
    endtask

    task automatic step1(input string tag);
        bit          s;
        logic [31:0] o;
        step(tag, s, o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("reset/cnt",   {16'b0, ofi.stall_cnt}, 32'h0);
        check("reset/stall", {31'b0, ofi.stall}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          v;
        int          r1;
        int          r2;
        int          rd;
        bit          we;
        bit          ld;
        logic [31:0] ex;
        logic [31:0] mem;
        logic [31:0] wb;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          est;
        int          ecnt;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input bit v, input int r1, input int r2, input int rd,
                                input bit we, input bit ld,
                                input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
                                input logic [31:0] d1, input logic [31:0] d2);
        vec_t t;
        t.v = v; t.r1 = r1; t.r2 = r2; t.rd = rd; t.we = we; t.ld = ld;
        t.ex = ex; t.mem = mem; t.wb = wb; t.d1 = d1; t.d2 = d2;
        t.e1 = 32'h0; t.e2 = 32'h0; t.est = 1'b0; t.ecnt = 0;
        return t;
    endfunction

    task automatic setexp(input int i, input logic [31:0] e1, input logic [31:0] e2,
                          input bit st, input int c);
        tbl[i].e1   = e1;
        tbl[i].e2   = e2;
        tbl[i].est  = st;
        tbl[i].ecnt = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          s;
        logic [31:0] o;
        int          n_st;
        int          exp_n;
        logic [31:0] exp_o;

        //                v  r1 r2 rd we ld  ex        mem        wb       d1         d2
        tbl[0]  = mk(1, 0, 0, 5, 1, 0, 32'h0,  32'h0,    32'h0,  32'hAAAA, 32'hBBBB); // add x5
        tbl[1]  = mk(1, 5, 3, 6, 1, 1, 32'h11, 32'h22,   32'h33, 32'h100,  32'h200);  // lw x6, reads x5
        tbl[2]  = mk(1, 1, 6, 8, 1, 0, 32'h44, 32'hDEAD, 32'h77, 32'h101,  32'h202);  // load-use on x6
        tbl[3]  = mk(1, 1, 6, 8, 1, 0, 32'h99, 32'hDEAD, 32'h11, 32'h101,  32'h202);  // retry
        tbl[4]  = mk(1, 7, 0, 7, 1, 0, 32'h0,  32'h0,    32'h0,  32'h300,  32'hCCCC); // add x7 (old)
        tbl[5]  = mk(1, 0, 0, 7, 1, 0, 32'h0,  32'h0,    32'h0,  32'h333,  32'h444);  // add x7 (new)
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,  32'h1,    32'h2);    // idle
        tbl[7]  = mk(1, 7, 7, 0, 0, 0, 32'h9,  32'h2,    32'h3,  32'h400,  32'h500);  // x7 in MEM+WB
        tbl[8]  = mk(1, 7, 2, 0, 1, 0, 32'h9,  32'h8,    32'h3,  32'h600,  32'h55);   // x7 only in WB
        tbl[9]  = mk(1, 0, 0, 0, 1, 1, 32'h55, 32'h0,    32'h0,  32'h700,  32'h800);  // x0 in EX
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 32'h55, 32'h0,    32'h0,  32'h900,  32'hA00);  // x0 load in EX
`ifdef OPERAND_FETCH_FWD_EN
        setexp(0,  32'h0,   32'h0,    0, 0);
        setexp(1,  32'h11,  32'h200,  0, 0);
        setexp(2,  32'h101, 32'h44,   1, 0);
        setexp(3,  32'h101, 32'hDEAD, 0, 1);
        setexp(4,  32'h300, 32'h0,    0, 1);
        setexp(5,  32'h0,   32'h0,    0, 1);
        setexp(6,  32'h0,   32'h0,    0, 1);
        setexp(7,  32'h2,   32'h2,    0, 1);
        setexp(8,  32'h3,   32'h55,   0, 1);
        setexp(9,  32'h0,   32'h0,    0, 1);
        setexp(10, 32'h0,   32'h0,    0, 1);
        exp_n = 0;
        exp_o = 32'h9999;
`else
        setexp(0,  32'h0,   32'h0,    0, 0);
        setexp(1,  32'h100, 32'h200,  1, 0);
        setexp(2,  32'h101, 32'h202,  0, 1);
        setexp(3,  32'h101, 32'h202,  0, 1);
        setexp(4,  32'h300, 32'h0,    0, 1);
        setexp(5,  32'h0,   32'h0,    0, 1);
        setexp(6,  32'h0,   32'h0,    0, 1);
        setexp(7,  32'h400, 32'h500,  1, 1);
        setexp(8,  32'h600, 32'h55,   1, 2);
        setexp(9,  32'h0,   32'h0,    0, 3);
        setexp(10, 32'h0,   32'h0,    0, 3);
        exp_n = 3;
        exp_o = 32'h1234;
`endif

        // ---- table ----
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].we, tbl[i].ld, 1'b0,
                  tbl[i].ex, tbl[i].mem, tbl[i].wb, tbl[i].d1, tbl[i].d2);
            @(negedge clk);
            $display("[row%0d] rs1=%0d rs2=%0d -> op1=%h op2=%h stall=%0d cnt=%0d",
                     i, ofi.rs1, ofi.rs2, ofi.op1, ofi.op2, ofi.stall, ofi.stall_cnt);
            check($sformatf("row%0d/op1", i),   ofi.op1, tbl[i].e1);
            check($sformatf("row%0d/op2", i),   ofi.op2, tbl[i].e2);
            check($sformatf("row%0d/stall", i), {31'b0, ofi.stall}, {31'b0, tbl[i].est});
            check($sformatf("row%0d/cnt", i),   {16'b0, ofi.stall_cnt}, 32'(tbl[i].ecnt));
            @(posedge clk);
            #1;
        end

        // ---- flush during a load-use hazard ----
        do_reset();
        drive(1, 0, 0, 6, 1, 1, 0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);         // lw x6
        step1("fl_lw");
        drive(1, 0, 6, 6, 1, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);         // user, flushed
        step("fl_kill", s, o);
        check("fl_kill/no_stall", {31'b0, s}, 32'h0);
        drive(1, 0, 6, 0, 0, 0, 0, 32'h1, 32'hDEAD, 32'h3, 32'h4, 32'h5);      // EX must be a bubble
        step1("fl_next");
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step1("fl_drain");

        // ---- dependent ALU instruction: interlock length ----
        do_reset();
        drive(1, 0, 0, 9, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);         // add x9
        step1("ilk_add");
        n_st = 0;
        o    = 32'h0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 9, 0, 10, 1, 0, 0, 32'h9999, 32'h8888, 32'h7777, 32'h1234, 32'h0);
            step("ilk_use", s, o);
            if (!s) break;
            n_st++;
        end
        check("ilk/stall_cycles", 32'(n_st), 32'(exp_n));
        check("ilk/op1_after",    o, exp_o);

        // ---- asynchronous reset mid-stream ----
        do_reset();
        drive(1, 0, 0, 4, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);         // lw x4
        step1("rst_lw");
        drive(1, 4, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h4444, 32'h0);      // stalls in both builds
        step1("rst_use");
        drive(1, 0, 0, 4, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);         // lw x4 again
        step1("rst_lw2");
        drive(1, 4, 4, 0, 0, 0, 0, 32'hE0E0, 32'hE1E1, 32'hE2E2, 32'h4444, 32'h5555);
        #1;
        check("pre_rst/cnt",   {16'b0, ofi.stall_cnt}, 32'h1);
        check("pre_rst/stall", {31'b0, ofi.stall}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst/cnt",   {16'b0, ofi.stall_cnt}, 32'h0);
        check("async_rst/stall", {31'b0, ofi.stall}, 32'h0);
        check("async_rst/op1",   ofi.op1, 32'h4444);
        check("async_rst/op2",   ofi.op2, 32'h5555);
        @(posedge clk);
        #1;
        check("held_rst/cnt",   {16'b0, ofi.stall_cnt}, 32'h0);
        check("held_rst/stall", {31'b0, ofi.stall}, 32'h0);
        rst_n = 1'b1;
        m_reset();
        drive(1, 0, 0, 4, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step1("post_rst_lw");
        drive(1, 4, 0, 0, 0, 0, 0, 32'hABCD, 32'h0, 32'h0, 32'h4444, 32'h0);
        step1("post_rst_use");
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step1("post_rst_idle");

        // ---- randomized phase ----
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                  $urandom, $urandom, $urandom, $urandom, $urandom);
            step1("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
